// File: rtl/egg_ctrl_pkg.sv
// egg_ctrl_pkg: shared state encoding, word width and page-width helper for the egg-drop controller
package egg_ctrl_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;
  function automatic int page_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/egg_test_ctrl_tick_gen.sv
// tick_gen: free-running 2^DIV_K divider; tick is high while enabled in the all-ones cycle
module tick_gen #(
  parameter int DIV_K = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  logic [DIV_K-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign tick = enable && (&cnt);
endmodule

// File: rtl/egg_test_ctrl.sv
// egg_test_ctrl: config latch, gated CPU enable, run/watchdog FSM and display paging on one clock
module egg_test_ctrl
  import egg_ctrl_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          NUM_CFG   = 2,
  parameter int          NUM_RES   = 4,
  parameter int          DIV_K     = 4,
  parameter int unsigned MAX_TICKS = 32'd1 << 20,
  parameter int          HOLD_K    = 24
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DATA_W-1:0]           in_data_i,
  input  logic [NUM_CFG-1:0]          cfg_load_i,
  input  logic                        start_i,
  input  logic                        cpu_done_i,
  input  logic [WORD_W*NUM_RES-1:0]   result_i,
  input  logic                        auto_page_i,
  input  logic                        page_next_i,
  output logic [WORD_W*NUM_CFG-1:0]   cfg_o,
  output logic                        cpu_ce_o,
  output logic                        cpu_clr_o,
  output logic [1:0]                  state_o,
  output logic [page_w(NUM_RES)-1:0]  page_o,
  output logic [WORD_W-1:0]           disp_data_o
);
  localparam int PW = page_w(NUM_RES);
  state_t             state, nxt;
  logic [NUM_CFG-1:0] valid;
  logic [31:0]        ticks;
  logic               auto_q, div_tick, hold_tick, hit, go, moved, adv;
  logic [PW-1:0]      lim;
  int                 pidx;
  assign state_o = state;
  assign go      = (state == S_IDLE) && (nxt == S_RUN);
  assign moved   = nxt != state;
  assign hit     = cpu_ce_o && (({1'b0, ticks} + 33'd1) >= 33'(MAX_TICKS));
  assign adv     = auto_page_i ? hold_tick : page_next_i;
  assign lim     = (state == S_IDLE) ? PW'(NUM_CFG - 1) : PW'(NUM_RES - 1);
  assign pidx    = int'(page_o);
  // done is checked before the watchdog so a same-cycle finish is reported as DONE
  always_comb
    nxt = (state == S_IDLE) ? ((start_i && (&valid)) ? S_RUN : S_IDLE) :
          (state == S_RUN)  ? (cpu_done_i ? S_DONE : hit ? S_TIMEOUT : S_RUN) :
          (start_i ? S_IDLE : state);
  tick_gen #(.DIV_K(DIV_K)) u_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (go),
    .enable (state == S_RUN),
    .tick   (div_tick)
  );
  tick_gen #(.DIV_K(HOLD_K)) u_hold (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (moved || adv || (auto_page_i != auto_q)),
    .enable (auto_page_i),
    .tick   (hold_tick)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state       <= S_IDLE;
      valid       <= '0;
      cfg_o       <= '0;
      ticks       <= '0;
      cpu_ce_o    <= 1'b0;
      cpu_clr_o   <= 1'b0;
      page_o      <= '0;
      disp_data_o <= '0;
      auto_q      <= 1'b0;
    end else begin
      state       <= nxt;
      cpu_clr_o   <= go;
      cpu_ce_o    <= div_tick && (nxt == S_RUN);
      ticks       <= go ? '0 : (cpu_ce_o && !(&ticks)) ? ticks + 32'd1 : ticks;
      auto_q      <= auto_page_i;
      page_o      <= moved ? '0 : adv ? ((page_o >= lim) ? '0 : page_o + 1'b1) : page_o;
      disp_data_o <= (state == S_IDLE) ?
                     ((pidx < NUM_CFG) ? cfg_o[pidx*WORD_W +: WORD_W] : '0) :
                     result_i[pidx*WORD_W +: WORD_W];
      for (int k = 0; k < NUM_CFG; k++)
        if (cfg_load_i[k] && (state != S_RUN)) begin
          cfg_o[k*WORD_W +: WORD_W] <= WORD_W'(in_data_i);
          valid[k]                  <= 1'b1;
        end
    end
endmodule
